fwrisc_seq_comparator: RTL and testbench

Parametrised, multi-cycle successor to the single-cycle comparator, sized for area-minimal fwrisc configurations.
- Evaluates all six RISC-V branch conditions (EQ, NE, LT, GE, LTU, GEU) serially, one CHUNK-bit slice per cycle, MSB slice first.
- Sits between the register-read stage and the branch/SLT result mux.
- Uses valid/ready handshakes on both input and output.

---
 rtl/fwrisc_cmp_pkg.sv | 37 +++
 rtl/fwrisc_cmp_slice.sv | 26 ++
 rtl/fwrisc_seq_comparator.sv | 132 +++++++++++++
 tb/tb_fwrisc_seq_comparator.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/fwrisc_cmp_pkg.sv
// Shared types and helpers for the sequential fwrisc branch comparator.
package fwrisc_cmp_pkg;

    // RISC-V branch funct3 encoding; 3'b010 and 3'b011 are reserved.
    typedef enum logic [2:0] {
        CMP_EQ  = 3'd0,
        CMP_NE  = 3'd1,
        CMP_LT  = 3'd4,
        CMP_GE  = 3'd5,
        CMP_LTU = 3'd6,
        CMP_GEU = 3'd7
    } compare_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cmp_state_e;

    function automatic logic is_signed(input logic [2:0] op);
        return (op == CMP_LT) || (op == CMP_GE);
    endfunction

    // Final result from the accumulated first-difference flags.
    function automatic logic cmp_result(input logic [2:0] op, input logic diff, input logic lt);
        logic r;
        case (op)
            CMP_EQ:           r = !diff;
            CMP_NE:           r = diff;
            CMP_LT, CMP_LTU:  r = diff && lt;
            CMP_GE, CMP_GEU:  r = !(diff && lt);
            default:          r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/fwrisc_cmp_slice.sv
// Combinational CHUNK-wide slice compare. invert_msb flips the slice MSB of
// both operands so a signed top slice can be compared as unsigned.
module fwrisc_cmp_slice #(
    parameter int unsigned CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             invert_msb,
    output logic             ne,
    output logic             lt
);

    logic [CHUNK-1:0] a_m;
    logic [CHUNK-1:0] b_m;

    // Bias the sign bit, then compare unsigned.
    always_comb begin
        a_m            = a;
        b_m            = b;
        a_m[CHUNK-1]   = a[CHUNK-1] ^ invert_msb;
        b_m[CHUNK-1]   = b[CHUNK-1] ^ invert_msb;
        ne             = (a_m != b_m);
        lt             = (a_m < b_m);
    end

endmodule

// File: rtl/fwrisc_seq_comparator.sv
// Multi-cycle branch comparator: one CHUNK-bit slice per cycle, MSB first,
// valid/ready on input and output.
// Optional: define FWRISC_SEQ_CMP_EARLY_EXIT_EN to leave RUN as soon as the
// first differing slice is seen (variable latency).
module fwrisc_seq_comparator
    import fwrisc_cmp_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out,
    output logic             busy
);

    localparam int unsigned N  = WIDTH / CHUNK;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] TOP_IDX = CW'(N - 1);

    generate
        if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
            $error("fwrisc_seq_comparator: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    cmp_state_e       state_q;
    logic [CW-1:0]    cnt_q;
    logic             diff_q;
    logic             lt_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [2:0]       op_q;
    logic             out_q;
    logic             out_valid_q;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [CHUNK-1:0] a_slice;
    logic [CHUNK-1:0] b_slice;
    logic             invert_msb;
    logic             s_ne;
    logic             s_lt;
    logic             diff_d;
    logic             lt_d;
    logic             last;
    logic             exit_run;

    // Select the current slice and fold it into the first-difference state.
    always_comb begin
        a_sh       = a_q >> (32'(cnt_q) * CHUNK);
        b_sh       = b_q >> (32'(cnt_q) * CHUNK);
        a_slice    = a_sh[CHUNK-1:0];
        b_slice    = b_sh[CHUNK-1:0];
        invert_msb = is_signed(op_q) && (cnt_q == TOP_IDX);
        diff_d     = diff_q | s_ne;
        lt_d       = diff_q ? lt_q : s_lt;
        last       = (cnt_q == '0);
`ifdef FWRISC_SEQ_CMP_EARLY_EXIT_EN
        exit_run   = last || (!diff_q && s_ne);
`else
        exit_run   = last;
`endif
    end

    fwrisc_cmp_slice #(
        .CHUNK (CHUNK)
    ) u_slice (
        .a          (a_slice),
        .b          (b_slice),
        .invert_msb (invert_msb),
        .ne         (s_ne),
        .lt         (s_lt)
    );

    // Control FSM with registered result and valid.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            diff_q      <= 1'b0;
            lt_q        <= 1'b0;
            out_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= in_a;
                        b_q     <= in_b;
                        op_q    <= op;
                        cnt_q   <= TOP_IDX;
                        diff_q  <= 1'b0;
                        lt_q    <= 1'b0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    diff_q <= diff_d;
                    lt_q   <= lt_d;
                    if (exit_run) begin
                        out_q       <= cmp_result(op_q, diff_d, lt_d);
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out       = out_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_fwrisc_seq_comparator.sv
// Directed bench: five comparator instances (CHUNK = 1, 4, 8, 16, 32) share
// stimulus; expected results are hand-computed per vector.
module tb_fwrisc_seq_comparator;

    localparam int NI   = 5;
    localparam int MAIN = 2;   // CHUNK = 8 instance

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          out_ready;
    logic [31:0]   in_a;
    logic [31:0]   in_b;
    logic [2:0]    op;
    logic [NI-1:0] in_ready_w;
    logic [NI-1:0] out_valid_w;
    logic [NI-1:0] out_w;
    logic [NI-1:0] busy_w;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    function automatic int chunk_of(input int g);
        return (g == 0) ? 1 : (2 << g);
    endfunction

    generate
        for (genvar g = 0; g < NI; g++) begin : g_dut
            fwrisc_seq_comparator #(
                .WIDTH (32),
                .CHUNK ((g == 0) ? 1 : (2 << g))
            ) u_dut (
                .clock     (clk),
                .reset     (rst),
                .in_valid  (in_valid),
                .in_ready  (in_ready_w[g]),
                .in_a      (in_a),
                .in_b      (in_b),
                .op        (op),
                .out_valid (out_valid_w[g]),
                .out_ready (out_ready),
                .out       (out_w[g]),
                .busy      (busy_w[g])
            );
        end
    endgenerate

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected cycles from acceptance to out_valid.
    function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b, input int ch);
        int n;
        n = 32 / ch;
`ifdef FWRISC_SEQ_CMP_EARLY_EXIT_EN
        for (int k = 1; k <= n; k++) begin
            logic [31:0] m;
            m = ((ch == 32) ? 32'hFFFF_FFFF : ((32'd1 << ch) - 32'd1)) << ((n - k) * ch);
            if ((a & m) != (b & m)) return k;
        end
`endif
        return n;
    endfunction

    task automatic run_vec(input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] o, input logic e);
        logic [NI-1:0] seen;
        int cyc;
        @(negedge clk);
        in_a = a; in_b = b; op = o; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a = ~a; in_b = a ^ 32'h5A5A_5A5A; op = ~o;
        check("accept_busy", 32'(busy_w), 32'h1F);
        check("accept_in_ready", 32'(in_ready_w), 32'h0);
        seen = '0;
        cyc  = 0;
        while (seen != '1 && cyc < 40) begin
            cyc++;
            @(posedge clk); #1;
            for (int g = 0; g < NI; g++) begin
                if (!seen[g] && out_valid_w[g]) begin
                    seen[g] = 1'b1;
                    check($sformatf("lat_c%0d", chunk_of(g)), cyc, exp_lat(a, b, chunk_of(g)));
                    check($sformatf("out_c%0d", chunk_of(g)), 32'(out_w[g]), 32'(e));
                end
            end
            check("run_in_ready", 32'(in_ready_w[MAIN]), 32'h0);
        end
        check("all_done", 32'(seen), 32'h1F);
        repeat (5) begin
            @(posedge clk); #1;
            check("hold_valid", 32'(out_valid_w), 32'h1F);
            check("hold_out", 32'(out_w), e ? 32'h1F : 32'h0);
            check("hold_in_ready", 32'(in_ready_w), 32'h0);
        end
        // Release with a competing request: it must not be taken in DONE.
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; in_a = a; in_b = b; op = o;
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b0;
        check("release_valid", 32'(out_valid_w), 32'h0);
        check("release_in_ready", 32'(in_ready_w), 32'h1F);
        check("no_overlap_busy", 32'(busy_w), 32'h0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; op = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready_w), 32'h1F);
        check("rst_busy", 32'(busy_w), 32'h0);
        check("rst_out_valid", 32'(out_valid_w), 32'h0);
        check("rst_out", 32'(out_w), 32'h0);
        rst = 1'b0;

        run_vec(32'h1234_5678, 32'h1234_5678, 3'b000, 1'b1); // EQ
        run_vec(32'h1234_5678, 32'h1234_5678, 3'b001, 1'b0); // NE
        run_vec(32'hFFFF_FFFF, 32'h0000_0001, 3'b100, 1'b1); // LT  -1 < 1
        run_vec(32'hFFFF_FFFF, 32'h0000_0001, 3'b110, 1'b0); // LTU
        run_vec(32'hFFFF_FFFF, 32'h0000_0001, 3'b111, 1'b1); // GEU
        run_vec(32'h8000_0000, 32'h7FFF_FFFF, 3'b101, 1'b0); // GE  min >= max
        run_vec(32'h8000_0000, 32'h7FFF_FFFF, 3'b111, 1'b1); // GEU
        run_vec(32'h7FFF_FFFF, 32'h8000_0000, 3'b101, 1'b1); // GE
        run_vec(32'h0000_0005, 32'h0000_0005, 3'b010, 1'b0); // reserved
        run_vec(32'h0000_0005, 32'h0000_0005, 3'b011, 1'b0); // reserved
        run_vec(32'h0000_0003, 32'h0000_0005, 3'b100, 1'b1); // LT
        run_vec(32'h1234_5678, 32'h1234_5679, 3'b001, 1'b1); // NE, LSB slice only
        run_vec(32'hFFFF_FFFE, 32'hFFFF_FFFF, 3'b100, 1'b1); // LT  -2 < -1
        run_vec(32'h0000_0010, 32'h0000_0010, 3'b101, 1'b1); // GE equal
        run_vec(32'h0000_0010, 32'h0000_0010, 3'b110, 1'b0); // LTU equal

        // Reset in the second RUN cycle abandons the operation.
        @(negedge clk);
        in_a = 32'h0000_0001; in_b = 32'h0000_0002; op = 3'b100; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_busy", 32'(busy_w), 32'h0);
        check("midrst_out_valid", 32'(out_valid_w), 32'h0);
        check("midrst_in_ready", 32'(in_ready_w), 32'h1F);
        run_vec(32'h0000_0001, 32'h0000_0002, 3'b100, 1'b1); // fresh request

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
